// File: rtl/adder_accum_if.sv
// Handshaked operand/result bundle for adder_accum.
// The slave side is the accumulator and the master side is whoever drives operands and takes results.
interface adder_accum_if #(
  parameter int BITWIDTH = 32,
  parameter int ACC_LEN  = 8
);
  localparam int CNTW = $clog2(ACC_LEN + 1);
  localparam int OUTW = BITWIDTH + 1 + $clog2(ACC_LEN);

  logic                iValid;
  logic                oReady;
  logic                iLast;
  logic [BITWIDTH-1:0] iData0;
  logic [BITWIDTH-1:0] iData1;
  logic                oValid;
  logic                iReady;
  logic [OUTW-1:0]     oData;
  logic [CNTW-1:0]     oCnt;

  modport slave (
    input  iValid, iLast, iData0, iData1, iReady,
    output oReady, oValid, oData, oCnt
  );

  modport master (
    output iValid, iLast, iData0, iData1, iReady,
    input  oReady, oValid, oData, oCnt
  );
endinterface

// File: rtl/adder_accum.sv
// Handshaked accumulator: sums iData0+iData1 over up to ACC_LEN beats (or until iLast),
// then presents the total and its beat count until downstream takes it.
module adder_accum #(
  parameter int BITWIDTH = 32,
  parameter int ACC_LEN  = 8
) (
  input  logic           iClk,
  input  logic           iRstN,
  input  logic           iClr,
  adder_accum_if.slave   bus
);
  localparam int CNTW = $clog2(ACC_LEN + 1);
  localparam int OUTW = BITWIDTH + 1 + $clog2(ACC_LEN);

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t          r_state;
  logic [OUTW-1:0] r_acc;
  logic [CNTW-1:0] r_cnt;
  logic [OUTW-1:0] r_data;
  logic [CNTW-1:0] r_outCnt;
  logic            r_valid;

  logic            w_ready;
  logic            w_accept;
  logic            w_close;
  logic [OUTW-1:0] w_sum;
  logic [OUTW-1:0] w_accN;
  logic [CNTW-1:0] w_cntInc;

  // Ready is withheld combinationally during reset/clear so no beat slips in on that edge.
  assign w_ready  = iRstN && !iClr && (r_state == S_ACC);
  assign w_accept = bus.iValid && w_ready;
  assign w_close  = (r_cnt == CNTW'(ACC_LEN - 1)) || bus.iLast;
  assign w_sum    = OUTW'(bus.iData0) + OUTW'(bus.iData1);
  assign w_accN   = (r_cnt == '0) ? w_sum : (r_acc + w_sum);
  assign w_cntInc = r_cnt + CNTW'(1);

  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      r_state  <= S_ACC;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_outCnt <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            if (w_close) begin
              r_data   <= w_accN;
              r_outCnt <= w_cntInc;
              r_cnt    <= '0;
              r_valid  <= 1'b1;
              r_state  <= S_OUT;
            end else begin
              r_acc <= w_accN;
              r_cnt <= w_cntInc;
            end
          end
        end
        S_OUT: begin
          // Result registers stay frozen until the downstream handshake completes.
          if (bus.iReady) begin
            r_valid <= 1'b0;
            r_state <= S_ACC;
          end
        end
      endcase
    end
  end

  assign bus.oReady = w_ready;
  assign bus.oValid = r_valid;
  assign bus.oData  = r_data;
  assign bus.oCnt   = r_outCnt;
endmodule

// File: tb/tb_adder_accum.sv
// Scoreboard bench for adder_accum: instance A (16-bit, 4 beats) covers grouping and handshakes,
// instance B (8-bit, 8 beats) covers the no-wrap width bound.
module tb_adder_accum;
  localparam int BW_A  = 16;
  localparam int LEN_A = 4;
  localparam int BW_B  = 8;
  localparam int LEN_B = 8;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  logic iClk = 1'b0;
  logic iRstN;
  logic iClr;

  exp_t qA[$];
  exp_t qB[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  adder_accum_if #(.BITWIDTH(BW_A), .ACC_LEN(LEN_A)) busA ();
  adder_accum_if #(.BITWIDTH(BW_B), .ACC_LEN(LEN_B)) busB ();

  adder_accum #(.BITWIDTH(BW_A), .ACC_LEN(LEN_A)) dutA (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iClr),
    .bus   (busA)
  );

  adder_accum #(.BITWIDTH(BW_B), .ACC_LEN(LEN_B)) dutB (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iClr),
    .bus   (busB)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  // Monitors compare only on a real output handshake, seen at the negedge before it commits.
  always @(negedge iClk) begin
    exp_t e;
    if (busA.oValid === 1'b1 && busA.iReady === 1'b1) begin
      if (qA.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL A unexpected result: got data %0d, expected none", busA.oData);
      end else begin
        e = qA.pop_front();
        checkOutput("A oData", 32'(busA.oData), e.data);
        checkOutput("A oCnt", 32'(busA.oCnt), e.cnt);
      end
    end
  end

  always @(negedge iClk) begin
    exp_t e;
    if (busB.oValid === 1'b1 && busB.iReady === 1'b1) begin
      if (qB.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL B unexpected result: got data %0d, expected none", busB.oData);
      end else begin
        e = qB.pop_front();
        checkOutput("B oData", 32'(busB.oData), e.data);
        checkOutput("B oCnt", 32'(busB.oCnt), e.cnt);
      end
    end
  end

  // Beat drivers hold the beat until oReady is seen, then return at posedge+1 with iValid low.
  task automatic applyStimulus(input logic [BW_A-1:0] d0, input logic [BW_A-1:0] d1, input logic last);
    int waitCycles = 0;
    busA.iValid = 1'b1;
    busA.iData0 = d0;
    busA.iData1 = d1;
    busA.iLast  = last;
    while (1) begin
      @(negedge iClk);
      if (busA.oReady === 1'b1) break;
      waitCycles++;
      if (waitCycles > 50) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL A beat accept timeout: got oReady %b, expected 1", busA.oReady);
        break;
      end
    end
    @(posedge iClk);
    #1;
    busA.iValid = 1'b0;
    busA.iLast  = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [BW_B-1:0] d0, input logic [BW_B-1:0] d1, input logic last);
    int waitCycles = 0;
    busB.iValid = 1'b1;
    busB.iData0 = d0;
    busB.iData1 = d1;
    busB.iLast  = last;
    while (1) begin
      @(negedge iClk);
      if (busB.oReady === 1'b1) break;
      waitCycles++;
      if (waitCycles > 50) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL B beat accept timeout: got oReady %b, expected 1", busB.oReady);
        break;
      end
    end
    @(posedge iClk);
    #1;
    busB.iValid = 1'b0;
    busB.iLast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRstN       = 1'b0;
    iClr        = 1'b0;
    busA.iValid = 1'b1;
    busA.iLast  = 1'b0;
    busA.iData0 = 16'd3;
    busA.iData1 = 16'd4;
    busA.iReady = 1'b1;
    busB.iValid = 1'b1;
    busB.iLast  = 1'b0;
    busB.iData0 = 8'd3;
    busB.iData1 = 8'd4;
    busB.iReady = 1'b1;

    // Reset held two clocks with valid beats offered.
    tick(2);
    @(negedge iClk);
    checkOutput("reset oValid", 32'(busA.oValid), 32'd0);
    checkOutput("reset oData", 32'(busA.oData), 32'd0);
    checkOutput("reset oCnt", 32'(busA.oCnt), 32'd0);
    checkOutput("reset oReady", 32'(busA.oReady), 32'd0);
    checkOutput("reset B oReady", 32'(busB.oReady), 32'd0);
    busA.iValid = 1'b0;
    busB.iValid = 1'b0;
    iRstN       = 1'b1;
    #1;
    checkOutput("release oReady", 32'(busA.oReady), 32'd1);
    checkOutput("release B oReady", 32'(busB.oReady), 32'd1);
    @(posedge iClk);
    #1;

    // Eight max-value beats must not wrap: 8 * 510 = 4080.
    qB.push_back('{32'd4080, 32'd8});
    for (int i = 0; i < LEN_B; i++) applyStimulusB(8'd255, 8'd255, 1'b0);
    checkOutput("B oValid after 8th beat", 32'(busB.oValid), 32'd1);

    // Full group of four closes on count: 3+7+11+15 = 36.
    qA.push_back('{32'd36, 32'd4});
    applyStimulus(16'd1, 16'd2, 1'b0);
    applyStimulus(16'd3, 16'd4, 1'b0);
    applyStimulus(16'd5, 16'd6, 1'b0);
    checkOutput("A oValid before close", 32'(busA.oValid), 32'd0);
    applyStimulus(16'd7, 16'd8, 1'b0);
    checkOutput("A oValid latency", 32'(busA.oValid), 32'd1);
    checkOutput("A oReady in S_OUT", 32'(busA.oReady), 32'd0);
    tick(1);
    checkOutput("A oValid after handoff", 32'(busA.oValid), 32'd0);
    checkOutput("A oReady after handoff", 32'(busA.oReady), 32'd1);

    // Early close on iLast, then a fresh single-beat group.
    qA.push_back('{32'd20, 32'd2});
    applyStimulus(16'd10, 16'd0, 1'b0);
    applyStimulus(16'd5, 16'd5, 1'b1);
    qA.push_back('{32'd5, 32'd1});
    applyStimulus(16'd2, 16'd3, 1'b1);

    // Idle gap with a stray iLast (iValid low) and iLast on the 4th beat.
    qA.push_back('{32'd8, 32'd4});
    applyStimulus(16'd1, 16'd1, 1'b0);
    busA.iLast = 1'b1;
    tick(2);
    busA.iLast = 1'b0;
    applyStimulus(16'd1, 16'd1, 1'b0);
    applyStimulus(16'd1, 16'd1, 1'b0);
    applyStimulus(16'd1, 16'd1, 1'b1);
    tick(2);

    // Backpressure: result held five cycles while a beat is offered.
    busA.iReady = 1'b0;
    qA.push_back('{32'd10, 32'd2});
    applyStimulus(16'd1, 16'd2, 1'b0);
    applyStimulus(16'd3, 16'd4, 1'b1);
    busA.iValid = 1'b1;
    busA.iData0 = 16'd9;
    busA.iData1 = 16'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      checkOutput("stall oReady", 32'(busA.oReady), 32'd0);
      checkOutput("stall oValid", 32'(busA.oValid), 32'd1);
      checkOutput("stall oData", 32'(busA.oData), 32'd10);
      @(posedge iClk);
      #1;
    end
    busA.iValid = 1'b0;
    busA.iReady = 1'b1;
    qA.push_back('{32'd2, 32'd1});
    applyStimulus(16'd1, 16'd1, 1'b1);

    // Clear mid-group discards the partial sum.
    applyStimulus(16'd50, 16'd50, 1'b0);
    applyStimulus(16'd50, 16'd50, 1'b0);
    iClr = 1'b1;
    @(negedge iClk);
    checkOutput("clear oReady", 32'(busA.oReady), 32'd0);
    @(posedge iClk);
    #1;
    iClr = 1'b0;
    qA.push_back('{32'd8, 32'd4});
    for (int i = 0; i < 4; i++) applyStimulus(16'd1, 16'd1, 1'b0);
    tick(2);

    // Clear while a result is pending drops it without a handshake.
    busA.iReady = 1'b0;
    applyStimulus(16'd7, 16'd7, 1'b1);
    checkOutput("pending oValid", 32'(busA.oValid), 32'd1);
    iClr = 1'b1;
    tick(1);
    iClr = 1'b0;
    checkOutput("cleared oValid", 32'(busA.oValid), 32'd0);
    checkOutput("cleared oData", 32'(busA.oData), 32'd0);
    checkOutput("cleared oCnt", 32'(busA.oCnt), 32'd0);
    busA.iReady = 1'b1;
    tick(2);
    qA.push_back('{32'd3, 32'd1});
    applyStimulus(16'd1, 16'd2, 1'b1);

    tick(4);
    checkOutput("A scoreboard drained", 32'(qA.size()), 32'd0);
    checkOutput("B scoreboard drained", 32'(qB.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
